// File: rtl/datapath_mc_pkg.sv
// Shared helpers for the multi-channel decimating datapath: widths, input
// difference with optional saturation, and output-mode encoding.
package datapath_mc_pkg;

    localparam logic MODE_DIFF  = 1'b0;
    localparam logic MODE_LEVEL = 1'b1;

    // Working width for the generic subtract helper; callers truncate.
    localparam int unsigned SUB_W = 32;

    function automatic int unsigned acc_width(input int unsigned w_in,
                                              input int unsigned ext);
        return w_in + ext;
    endfunction

    // a and b arrive sign-extended to SUB_W; result is meaningful in its low w bits.
    function automatic logic [SUB_W-1:0] sat_sub(input logic [SUB_W-1:0] a,
                                                 input logic [SUB_W-1:0] b,
                                                 input int unsigned      w,
                                                 input logic             sat);
        logic signed [SUB_W:0] d;
        logic signed [SUB_W:0] hi;
        logic signed [SUB_W:0] lo;
        d  = (SUB_W+1)'($signed(a)) - (SUB_W+1)'($signed(b));
        hi = ((SUB_W+1)'(1) <<< (w - 1)) - (SUB_W+1)'(1);
        lo = -((SUB_W+1)'(1) <<< (w - 1));
        if (sat && (d > hi)) begin
            return hi[SUB_W-1:0];
        end else if (sat && (d < lo)) begin
            return lo[SUB_W-1:0];
        end
        return d[SUB_W-1:0];
    endfunction

endpackage

// File: rtl/datapath_lane.sv
// One channel: p-n difference, error integrator against the held output,
// decimated output register and diff/level output mux.
module datapath_lane
    import datapath_mc_pkg::*;
#(
    parameter int unsigned W_IN           = 9,
    parameter int unsigned N_BITS_ACC_EXT = 3,
    parameter int unsigned SAT_INPUT      = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic            tick,
    input  logic            tick_d,
    input  logic            mode,
    input  logic [W_IN-1:0] p,
    input  logic [W_IN-1:0] n,
    output logic [W_IN-1:0] dout
);

    localparam int unsigned W_ACC = acc_width(W_IN, N_BITS_ACC_EXT);

    logic [W_ACC-1:0] acc;
    logic [W_IN-1:0]  out_q;
    logic [W_IN-1:0]  out_prev;
    logic [W_IN-1:0]  in_c;
    logic [W_IN-1:0]  err;
    logic [W_IN-1:0]  out_diff;

    always_comb begin
        in_c     = W_IN'(sat_sub(SUB_W'($signed(p)), SUB_W'($signed(n)), W_IN,
                                 SAT_INPUT != 0));
        err      = in_c - out_q;
        out_diff = out_q - out_prev;
    end

    // The tick edge samples the pre-update accumulator while the integrator
    // keeps running with the old output.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            out_q    <= '0;
            out_prev <= '0;
            dout     <= '0;
        end else begin
            if (enable) begin
                acc <= acc + W_ACC'($signed(err));
            end
            if (tick) begin
                out_q    <= acc[W_ACC-1:N_BITS_ACC_EXT];
                out_prev <= out_q;
            end
            if (tick_d) begin
                dout <= (mode == MODE_DIFF) ? out_diff : out_q;
            end
        end
    end

endmodule

// File: rtl/datapath_mc.sv
// Multi-channel decimating datapath: shared phase counter and frame strobes
// driving N_CH independent lanes.
module datapath_mc
    import datapath_mc_pkg::*;
#(
    parameter int unsigned N_CH           = 4,
    parameter int unsigned W_IN           = 9,
    parameter int unsigned N_BITS_ACC_EXT = 3,
    parameter int unsigned DEC_RATIO      = 8,
    parameter int unsigned SAT_INPUT      = 0
) (
    input  logic                 CLK_24M,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 mode,
    input  logic [N_CH*W_IN-1:0] counter_p,
    input  logic [N_CH*W_IN-1:0] counter_n,
    output logic [N_CH*W_IN-1:0] channel_output,
    output logic                 out_valid
);

    localparam int unsigned     PH_W    = $clog2(DEC_RATIO);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DEC_RATIO - 1);

    logic [PH_W-1:0] ph;
    logic            tick;
    logic            tick_d;

    assign tick = enable && (ph == PH_LAST);

    // Frame timing: ph advances only while enabled; valid trails tick by two edges.
    always_ff @(posedge CLK_24M) begin
        if (reset) begin
            ph        <= '0;
            tick_d    <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (enable) begin
                ph <= (ph == PH_LAST) ? '0 : ph + PH_W'(1);
            end
            tick_d    <= tick;
            out_valid <= tick_d;
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_lane
        datapath_lane #(
            .W_IN           (W_IN),
            .N_BITS_ACC_EXT (N_BITS_ACC_EXT),
            .SAT_INPUT      (SAT_INPUT)
        ) u_lane (
            .clk    (CLK_24M),
            .reset  (reset),
            .enable (enable),
            .tick   (tick),
            .tick_d (tick_d),
            .mode   (mode),
            .p      (counter_p[c*W_IN +: W_IN]),
            .n      (counter_n[c*W_IN +: W_IN]),
            .dout   (channel_output[c*W_IN +: W_IN])
        );
    end

endmodule

// File: tb/tb_datapath_mc.sv
// Bench for datapath_mc: wrap and saturating instances against an integer model.
module tb_datapath_mc;

    localparam int N_CH  = 4;
    localparam int W_IN  = 9;
    localparam int EXT   = 3;
    localparam int W_ACC = W_IN + EXT;
    localparam int DEC   = 8;
    localparam int MASK  = (1 << W_IN) - 1;

    logic                 clk;
    logic                 reset;
    logic                 enable;
    logic                 mode;
    logic [N_CH*W_IN-1:0] cp;
    logic [N_CH*W_IN-1:0] cn;
    logic [N_CH*W_IN-1:0] chout [2];
    logic                 vld   [2];

    int n_checks = 0;
    int n_fail   = 0;

    datapath_mc #(.N_CH(N_CH), .W_IN(W_IN), .N_BITS_ACC_EXT(EXT), .DEC_RATIO(DEC),
                  .SAT_INPUT(0)) dut0 (
        .CLK_24M(clk), .reset(reset), .enable(enable), .mode(mode),
        .counter_p(cp), .counter_n(cn), .channel_output(chout[0]), .out_valid(vld[0]));

    datapath_mc #(.N_CH(N_CH), .W_IN(W_IN), .N_BITS_ACC_EXT(EXT), .DEC_RATIO(DEC),
                  .SAT_INPUT(1)) dut1 (
        .CLK_24M(clk), .reset(reset), .enable(enable), .mode(mode),
        .counter_p(cp), .counter_n(cn), .channel_output(chout[1]), .out_valid(vld[1]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Interpret the low w bits of v as two's complement.
    function automatic int sx(input int v, input int w);
        int u;
        u = v & ((1 << w) - 1);
        return (u >= (1 << (w - 1))) ? u - (1 << w) : u;
    endfunction

    // Model state, indexed [instance][channel]; instance 1 saturates its input.
    int m_ph;
    bit m_tick_d;
    bit m_valid;
    bit m_init = 1'b0;
    int m_acc  [2][N_CH];
    int m_out  [2][N_CH];
    int m_prev [2][N_CH];
    int m_dout [2][N_CH];

    always @(posedge clk) begin
        bit tk;
        int inv, e, pre;
        tk = enable && (m_ph == DEC - 1);
        if (reset) begin
            m_ph = 0; m_tick_d = 0; m_valid = 0;
            for (int s = 0; s < 2; s++)
                for (int c = 0; c < N_CH; c++) begin
                    m_acc[s][c] = 0; m_out[s][c] = 0; m_prev[s][c] = 0; m_dout[s][c] = 0;
                end
        end else begin
            for (int s = 0; s < 2; s++)
                for (int c = 0; c < N_CH; c++) begin
                    if (m_tick_d)
                        m_dout[s][c] = mode ? m_out[s][c] : sx(m_out[s][c] - m_prev[s][c], W_IN);
                    inv = sx(int'(cp[c*W_IN +: W_IN]), W_IN) - sx(int'(cn[c*W_IN +: W_IN]), W_IN);
                    if (s == 1) begin
                        if (inv > 255) inv = 255;
                        if (inv < -256) inv = -256;
                    end else begin
                        inv = sx(inv, W_IN);
                    end
                    e   = sx(inv - m_out[s][c], W_IN);
                    pre = m_acc[s][c];
                    if (enable) m_acc[s][c] = sx(pre + e, W_ACC);
                    if (tk) begin
                        m_prev[s][c] = m_out[s][c];
                        m_out[s][c]  = pre >>> EXT;
                    end
                end
            m_valid  = m_tick_d;
            m_tick_d = tk;
            if (enable) m_ph = (m_ph + 1) % DEC;
        end
        m_init = 1'b1;
    end

    // Cycle-by-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        int act, exp;
        if (m_init) begin
            for (int s = 0; s < 2; s++) begin
                n_checks++;
                if (vld[s] !== m_valid) begin
                    n_fail++;
                    $display("FAIL out_valid inst%0d t=%0t got %0b expected %0b", s, $time, vld[s], m_valid);
                end
                for (int c = 0; c < N_CH; c++) begin
                    act = int'(chout[s][c*W_IN +: W_IN]);
                    exp = m_dout[s][c] & MASK;
                    n_checks++;
                    if (act != exp) begin
                        n_fail++;
                        $display("FAIL channel_output inst%0d ch%0d t=%0t got 0x%03h expected 0x%03h",
                                 s, c, $time, act, exp);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d (0x%03h) expected %0d (0x%03h)", name, $time, act, act, exp, exp);
        end
    endtask

    function automatic int ch_val(input int s, input int c);
        return int'(chout[s][c*W_IN +: W_IN]);
    endfunction

    // Count negedges until out_valid is seen (bounded); optionally check the count.
    task automatic wait_valid(input string name, input int exp);
        int k;
        bit seen;
        k = 0;
        seen = 0;
        while (!seen && k < 4 * DEC + 20) begin
            @(negedge clk);
            k++;
            seen = vld[0];
        end
        if (!seen) chk({name, "_timeout"}, k, -1);
        else if (exp > 0) chk(name, k, exp);
    endtask

    task automatic set_ch(input int c, input int p, input int n);
        cp[c*W_IN +: W_IN] = W_IN'(p);
        cn[c*W_IN +: W_IN] = W_IN'(n);
    endtask

    initial begin
        int k;
        bit seen;
        reset = 1'b1; enable = 1'b1; mode = 1'b0; cp = '0; cn = '0;
        repeat (3) @(negedge clk);

        // Mid-frame reset discards the partial frame.
        reset = 1'b0;
        set_ch(0, 10, 2);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            chk("reset_valid", int'(vld[s]), 0);
            for (int c = 0; c < N_CH; c++) chk("reset_output", ch_val(s, c), 0);
        end
        @(negedge clk);
        reset = 1'b0;
        wait_valid("first_valid_latency", 9);
        chk("dc_first_frame_diff", ch_val(0, 0), 7);

        // DC ramp-up: differentiated output settles to zero, level to 8.
        for (int f = 0; f < 30; f++) wait_valid("frame_period", DEC);
        chk("dc_settled_diff", ch_val(0, 0), 0);
        for (int c = 1; c < N_CH; c++) chk("idle_channel", ch_val(0, c), 0);
        mode = 1'b1;
        wait_valid("frame_period", DEC);
        chk("dc_settled_level", ch_val(0, 0), 8);
        chk("dc_settled_level_sat", ch_val(1, 0), 8);

        // Mode alternation on consecutive frames.
        for (int f = 0; f < 6; f++) begin
            mode = ~mode;
            wait_valid("frame_period", DEC);
            chk("mode_toggle", ch_val(0, 0), mode ? 8 : 0);
        end

        // Negative, independent and saturating channels.
        mode = 1'b1;
        set_ch(0, 3, 0);
        set_ch(1, 0, 5);
        set_ch(2, 200, 'h19C);
        set_ch(3, 0, 0);
        for (int f = 0; f < 30; f++) wait_valid("frame_period", DEC);
        chk("pos_small", ch_val(0, 0), 3);
        chk("neg_small", ch_val(0, 1), 'h1FB);
        chk("wrap_input", ch_val(0, 2), 'h12C);
        chk("sat_input", ch_val(1, 2), 'h0FF);
        chk("neg_small_sat", ch_val(1, 1), 'h1FB);

        // Enable dropped for 5 cycles at ph=3 stretches one frame to 13.
        k = 0;
        seen = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 2) enable = 1'b0;
            if (k == 7) enable = 1'b1;
            seen = vld[0];
        end
        chk("gated_period", k, 13);
        chk("gated_value", ch_val(0, 1), 'h1FB);
        chk("gated_value_sat", ch_val(1, 2), 'h0FF);
        wait_valid("post_gate_period", DEC);
        chk("post_gate_value", ch_val(0, 0), 3);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            for (int c = 0; c < N_CH; c++) set_ch(c, int'($urandom_range(0, 511)), int'($urandom_range(0, 511)));
            enable = ($urandom_range(0, 7) != 0);
            mode   = 1'($urandom_range(0, 1));
            reset  = ($urandom_range(0, 399) == 0);
        end
        reset = 1'b0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
